// File: rtl/rt_pkg.sv
// Shared types and constants for the JTAG debug transport module (TAP + DTM).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rt_pkg;

  localparam logic [31:0] DbgIdCode = 32'h2495_11C2;

  localparam logic [1:0] DmiOpNop   = 2'd0;
  localparam logic [1:0] DmiOpRead  = 2'd1;
  localparam logic [1:0] DmiOpWrite = 2'd2;

  localparam logic [1:0] DmiStatOk   = 2'd0;
  localparam logic [1:0] DmiStatFail = 2'd2;
  localparam logic [1:0] DmiStatBusy = 2'd3;

  localparam int unsigned DtmcsDmiReset  = 16;
  localparam int unsigned DtmcsHardReset = 17;

  typedef enum logic [4:0] {
    IR_IDCODE    = 5'h01,
    IR_DTMCS     = 5'h10,
    IR_DMIACCESS = 5'h11,
    IR_BYPASS    = 5'h1F
  } jtag_ir_e;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAUSE_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DMI_IDLE, DMI_REQ, DMI_WAIT
  } dmi_state_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  // Low 34 bits of the DMI scan register; the address sits above it.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_scan_t;

  // Unknown IR codes behave as BYPASS.
  function automatic jtag_ir_e ir_decode(input logic [4:0] ir);
    case (ir)
      5'h01:   return IR_IDCODE;
      5'h10:   return IR_DTMCS;
      5'h11:   return IR_DMIACCESS;
      default: return IR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/rt_jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller, stepped by a tck_rise strobe in the clk_i domain.
// Latency: state and decode flags change one clk after the tck_rise strobe.
// Backpressure: none; trst_n low forces TEST_LOGIC_RESET.
// Ports: clk_i/rst_ni, trst_n (synchronised), tck_rise, tms (synchronised) in;
//        one-hot decodes of the current state out (all registered).
module rt_jtag_tap_fsm
  import rt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trst_n,
  input  logic tck_rise,
  input  logic tms,
  output logic test_logic_reset,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);

  tap_state_e state, state_nxt;

  always_comb begin
    state_nxt = state;
    if (!trst_n) begin
      state_nxt = TAP_TLR;
    end else if (tck_rise) begin
      unique case (state)
        TAP_TLR:      state_nxt = tms ? TAP_TLR    : TAP_RTI;
        TAP_RTI:      state_nxt = tms ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_DR:   state_nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
        TAP_CAP_DR:   state_nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
        TAP_SH_DR:    state_nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
        TAP_EX1_DR:   state_nxt = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_nxt = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
        TAP_EX2_DR:   state_nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
        TAP_UPD_DR:   state_nxt = tms ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_IR:   state_nxt = tms ? TAP_TLR    : TAP_CAP_IR;
        TAP_CAP_IR:   state_nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
        TAP_SH_IR:    state_nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
        TAP_EX1_IR:   state_nxt = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_nxt = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
        TAP_EX2_IR:   state_nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
        TAP_UPD_IR:   state_nxt = tms ? TAP_SEL_DR : TAP_RTI;
        default:      state_nxt = TAP_TLR;
      endcase
    end
  end

  // Decodes are registered from the next state so they always describe
  // the state currently held; the action for a state fires on its tck_rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= TAP_TLR;
      test_logic_reset <= 1'b1;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      capture_ir       <= 1'b0;
      shift_ir         <= 1'b0;
      update_ir        <= 1'b0;
    end else begin
      state            <= state_nxt;
      test_logic_reset <= (state_nxt == TAP_TLR);
      capture_dr       <= (state_nxt == TAP_CAP_DR);
      shift_dr         <= (state_nxt == TAP_SH_DR);
      update_dr        <= (state_nxt == TAP_UPD_DR);
      capture_ir       <= (state_nxt == TAP_CAP_IR);
      shift_ir         <= (state_nxt == TAP_SH_IR);
      update_ir        <= (state_nxt == TAP_UPD_IR);
    end
  end

endmodule

// File: rtl/rt_jtag_dmi_tap.sv
// JTAG TAP + RISC-V DTM with oversampled pins; issues DMI requests to the debug module.
// Latency: JTAG pins see SyncStages+1 clk delay; dmi_req_valid_o rises the clk after UPDATE_DR.
// Backpressure: request held stable until dmi_req_ready_i; accesses while busy report sticky busy (3).
// Ports: clk_i/rst_ni; jtag_tck_i/tms_i/trst_ni/tdi_i in, jtag_tdo_o/tdo_oe_o out;
//        dmi_req_* (valid/ready/addr/op/data), dmi_resp_* (valid/ready/data/err), dmi_rst_no.
module rt_jtag_dmi_tap
  import rt_pkg::*;
#(
  parameter logic [31:0] IdCode     = DbgIdCode,
  parameter int unsigned AbitsW     = 7,
  parameter int unsigned SyncStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              jtag_tck_i,
  input  logic              jtag_tms_i,
  input  logic              jtag_trst_ni,
  input  logic              jtag_tdi_i,
  output logic              jtag_tdo_o,
  output logic              jtag_tdo_oe_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [AbitsW-1:0] dmi_req_addr_o,
  output logic [1:0]        dmi_req_op_o,
  output logic [31:0]       dmi_req_data_o,
  input  logic              dmi_resp_valid_i,
  output logic              dmi_resp_ready_o,
  input  logic [31:0]       dmi_resp_data_i,
  input  logic              dmi_resp_err_i,
  output logic              dmi_rst_no
);

  localparam int unsigned DrW = AbitsW + 34;

  // Pin synchronisers and tck edge detection
  logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
  logic tck_q, tck, tms, tdi, trst_n, tck_rise, tck_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      trst_sync <= '0;
      tck_q     <= 1'b0;
    end else begin
      tck_sync  <= {tck_sync[SyncStages-2:0], jtag_tck_i};
      tms_sync  <= {tms_sync[SyncStages-2:0], jtag_tms_i};
      tdi_sync  <= {tdi_sync[SyncStages-2:0], jtag_tdi_i};
      trst_sync <= {trst_sync[SyncStages-2:0], jtag_trst_ni};
      tck_q     <= tck_sync[SyncStages-1];
    end
  end

  assign tck      = tck_sync[SyncStages-1];
  assign tms      = tms_sync[SyncStages-1];
  assign tdi      = tdi_sync[SyncStages-1];
  assign trst_n   = trst_sync[SyncStages-1];
  assign tck_rise = tck & ~tck_q;
  assign tck_fall = ~tck & tck_q;

  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  rt_jtag_tap_fsm u_tap_fsm (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .trst_n           (trst_n),
    .tck_rise         (tck_rise),
    .tms              (tms),
    .test_logic_reset (tlr),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  logic [4:0]        ir, ir_shift;
  jtag_ir_e          ir_sel;
  logic [DrW-1:0]    dr, dr_capture, dr_shifted;
  logic              tdo, tdo_oe;
  dmi_state_e        dmi_state;
  logic              req_valid, dmi_rst_n;
  logic [AbitsW-1:0] req_addr;
  logic [1:0]        req_op, dmistat, cap_op;
  logic [31:0]       req_data, rdata;
  dtmcs_t            dtmcs;
  dmi_scan_t         cap_scan, upd_scan;

  assign ir_sel   = ir_decode(ir);
  assign upd_scan = dr[33:0];

  always_comb begin
    dtmcs         = '0;
    dtmcs.idle    = 3'd1;
    dtmcs.dmistat = dmistat;
    dtmcs.abits   = 6'(AbitsW);
    dtmcs.version = 4'd1;
    // Sticky status wins; otherwise an outstanding request reads as busy.
    cap_op = DmiOpNop;
    if (dmistat != DmiStatOk) cap_op = dmistat;
    else if (dmi_state != DMI_IDLE) cap_op = DmiStatBusy;
    cap_scan.data = rdata;
    cap_scan.op   = cap_op;
    unique case (ir_sel)
      IR_IDCODE:    dr_capture = DrW'({IdCode[31:1], 1'b1});
      IR_DTMCS:     dr_capture = DrW'(dtmcs);
      IR_DMIACCESS: dr_capture = {req_addr, cap_scan};
      default:      dr_capture = '0;
    endcase
  end

  // TDI enters at the top bit of whichever register is selected.
  always_comb begin
    dr_shifted = dr >> 1;
    unique case (ir_sel)
      IR_DMIACCESS: dr_shifted[DrW-1] = tdi;
      IR_BYPASS:    dr_shifted[0]     = tdi;
      default:      dr_shifted[31]    = tdi;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
      dr       <= '0;
      tdo      <= 1'b0;
      tdo_oe   <= 1'b0;
    end else begin
      tdo_oe <= shift_ir | shift_dr;
      if (!trst_n || tlr) begin
        ir <= IR_IDCODE;
      end else if (tck_rise) begin
        if (capture_ir) ir_shift <= 5'b00001;
        if (shift_ir)   ir_shift <= {tdi, ir_shift[4:1]};
        if (update_ir)  ir       <= ir_shift;
        if (capture_dr) dr       <= dr_capture;
        if (shift_dr)   dr       <= dr_shifted;
      end
      if (tck_fall) tdo <= shift_ir ? ir_shift[0] : dr[0];
    end
  end

  // DMI side: request/response handshake plus sticky status bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dmi_state <= DMI_IDLE;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_op    <= '0;
      req_data  <= '0;
      rdata     <= '0;
      dmistat   <= DmiStatOk;
      dmi_rst_n <= 1'b1;
    end else begin
      dmi_rst_n <= 1'b1;
      unique case (dmi_state)
        DMI_REQ: if (dmi_req_ready_i) begin
          req_valid <= 1'b0;
          if (dmi_resp_valid_i) begin
            dmi_state <= DMI_IDLE;
            rdata     <= dmi_resp_data_i;
            if (dmi_resp_err_i) dmistat <= DmiStatFail;
          end else begin
            dmi_state <= DMI_WAIT;
          end
        end
        DMI_WAIT: if (dmi_resp_valid_i) begin
          dmi_state <= DMI_IDLE;
          rdata     <= dmi_resp_data_i;
          if (dmi_resp_err_i) dmistat <= DmiStatFail;
        end
        default: ;
      endcase

      if (tck_rise && capture_dr && ir_sel == IR_DMIACCESS &&
          dmistat == DmiStatOk && dmi_state != DMI_IDLE)
        dmistat <= DmiStatBusy;

      if (tck_rise && update_dr && ir_sel == IR_DMIACCESS) begin
        if (dmi_state != DMI_IDLE) begin
          if (dmistat == DmiStatOk) dmistat <= DmiStatBusy;
        end else if (dmistat == DmiStatOk &&
                     (upd_scan.op == DmiOpRead || upd_scan.op == DmiOpWrite)) begin
          req_addr  <= dr[DrW-1:34];
          req_op    <= upd_scan.op;
          req_data  <= upd_scan.data;
          req_valid <= 1'b1;
          dmi_state <= DMI_REQ;
        end
      end

      if (tck_rise && update_dr && ir_sel == IR_DTMCS) begin
        if (dr[DtmcsDmiReset]) dmistat <= DmiStatOk;
        if (dr[DtmcsHardReset]) begin
          dmistat   <= DmiStatOk;
          dmi_state <= DMI_IDLE;
          req_valid <= 1'b0;
          dmi_rst_n <= 1'b0;
        end
      end

      // JTAG reset clears status only; an in-flight transaction runs to completion.
      if (!trst_n) dmistat <= DmiStatOk;
    end
  end

  assign jtag_tdo_o       = tdo;
  assign jtag_tdo_oe_o    = tdo_oe;
  assign dmi_req_valid_o  = req_valid;
  assign dmi_req_addr_o   = req_addr;
  assign dmi_req_op_o     = req_op;
  assign dmi_req_data_o   = req_data;
  assign dmi_resp_ready_o = 1'b1;
  assign dmi_rst_no       = dmi_rst_n;

endmodule
